// File: rtl/mult_pkg.sv
// Shared definitions for the multiply-accumulate stage: state encoding,
// default widths and the accumulator width check.
package mult_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_DONE  = ST_DONE
    } state_t;

    localparam int DEF_SIZE  = 16;
    localparam int DEF_ACC_W = 40;
    localparam int DEF_LEN_W = 8;

    function automatic bit acc_w_fits(input int size, input int acc_w);
        return acc_w >= 2 * size;
    endfunction

    localparam bit DEF_WIDTH_OK = acc_w_fits(DEF_SIZE, DEF_ACC_W);

endpackage

// File: rtl/mult_accumulator_if.sv
// Control, product handshake and result bus between the multiplier parent
// and the accumulate stage.
interface mult_accumulator_if
    import mult_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
);
    logic                start;
    logic [LEN_W-1:0]    length;
    logic                valid;
    logic [2*SIZE-1:0]   product;
    logic                ready;
    logic                busy;
    logic                done;
    logic [ACC_W-1:0]    result;
    logic                overflow;

    modport master (
        output start, length, valid, product,
        input  ready, busy, done, result, overflow
    );

    modport slave (
        input  start, length, valid, product,
        output ready, busy, done, result, overflow
    );
endinterface

// File: rtl/mult_accumulator.sv
// Sums a programmed number of unsigned products; one accepted product per cycle,
// done pulses the cycle after the last transfer; ready is a function of state only.
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    mult_accumulator_if.slave  bus
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        // extra MSB of the adder is the carry out of the accumulator
        sum     = {1'b0, acc_q} + (ACC_W+1)'(bus.product);
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = bus.length;
                    state_d = (bus.length == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.valid) begin
                    acc_d = sum[ACC_W-1:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ready    = (state_q == S_ACCUM);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = acc_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Randomized and directed checks of the accumulate stage against a plain-arithmetic sum model.
module tb_mult_accumulator;
    import mult_pkg::*;

    localparam int SIZE  = 16;
    localparam int ACC_W = 32;
    localparam int LEN_W = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mult_accumulator_if #(.SIZE(SIZE), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    mult_accumulator #(.SIZE(SIZE), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact sum; wrapped result and whether the exact sum left the accumulator range.
    function automatic logic [32:0] model_sum(input logic [31:0] p[$]);
        logic [63:0] s;
        s = 64'd0;
        foreach (p[i]) s = s + {32'd0, p[i]};
        return {(s >= 64'h1_0000_0000), s[31:0]};
    endfunction

    // Drives one run: start, products with bubbles (optionally poking start during bubbles),
    // and reports what was observed at done plus the cycle after.
    task automatic run_job(input int len, input logic [31:0] prods[$],
                           input int gap_min, input int gap_max, input int poke_len,
                           output logic [31:0] res, output logic ovf, output int xfers,
                           output int lag, output logic busy_s, output logic ready_s,
                           output logic busy_end, output bit timeout);
        int   idx, gap, since, cyc;
        logic xfer;
        bus.start  = 1'b1;
        bus.length = len[LEN_W-1:0];
        bus.valid  = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_s  = bus.busy;
        ready_s = bus.ready;
        idx = 0; gap = 0; since = 0; cyc = 0; xfers = 0;
        lag = -1; timeout = 1'b1; res = 'x; ovf = 1'bx;
        while (cyc < 300) begin
            if (bus.done) begin
                timeout = 1'b0;
                res = bus.result;
                ovf = bus.overflow;
                lag = since;
                break;
            end
            bus.start = 1'b0;
            if (gap > 0 || idx >= prods.size()) begin
                bus.valid = 1'b0;
                if (poke_len > 0) begin
                    bus.start  = 1'b1;
                    bus.length = poke_len[LEN_W-1:0];
                end
                if (gap > 0) gap = gap - 1;
                xfer = 1'b0;
            end else begin
                bus.valid   = 1'b1;
                bus.product = prods[idx];
                xfer = bus.ready;
            end
            @(posedge clk); #1;
            cyc++;
            if (xfer) begin
                idx++; xfers++; since = 0;
                gap = $urandom_range(gap_max, gap_min);
            end else begin
                since++;
            end
        end
        bus.valid = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        busy_end = bus.busy;
    endtask

    task automatic test_reset();
        logic [31:0] res; logic ovf, bs, rs, be; int x, lag; bit to;
        logic [31:0] q[$];
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.result, bus.busy, bus.ready, bus.done, bus.overflow} !== 36'd0) begin
            n_err++; $display("FAIL reset_hold: outputs=%h want 0", {bus.result, bus.busy, bus.ready, bus.done, bus.overflow});
        end
        rst = 1'b0;
        bus.start = 1'b1; bus.length = 8'd4;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.valid = 1'b1; bus.product = 32'd100;
        @(posedge clk); #1;
        bus.product = 32'd200;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        n_cmp++;
        if (bus.result !== 32'd300) begin
            n_err++; $display("FAIL reset_partial: result=%0d want 300", bus.result);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.result, bus.busy, bus.ready, bus.done, bus.overflow} !== 36'd0) begin
            n_err++; $display("FAIL reset_async: outputs=%h want 0", {bus.result, bus.busy, bus.ready, bus.done, bus.overflow});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.busy, bus.ready, bus.done} !== 3'b000) begin
            n_err++; $display("FAIL reset_after: busy/ready/done=%b want 000", {bus.busy, bus.ready, bus.done});
        end
        q = '{32'd5};
        run_job(1, q, 0, 0, 0, res, ovf, x, lag, bs, rs, be, to);
        n_cmp++;
        if (to || res !== 32'd5) begin
            n_err++; $display("FAIL reset_rerun: result=%0d timeout=%0d want 5", res, to);
        end
    endtask

    task automatic test_basic();
        logic [31:0] res; logic ovf, bs, rs, be; int x, lag; bit to;
        logic [31:0] q[$];
        q = '{32'd10, 32'd20, 32'd30};
        run_job(3, q, 0, 0, 0, res, ovf, x, lag, bs, rs, be, to);
        n_cmp++;
        if (to || res !== 32'd60 || ovf !== 1'b0) begin
            n_err++; $display("FAIL basic_sum: result=%0d ovf=%b timeout=%0d want 60/0", res, ovf, to);
        end
        n_cmp++;
        if (x != 3 || lag != 0) begin
            n_err++; $display("FAIL basic_done_timing: xfers=%0d lag=%0d want 3/0", x, lag);
        end
        n_cmp++;
        if (bs !== 1'b1 || rs !== 1'b1 || be !== 1'b0) begin
            n_err++; $display("FAIL basic_busy: start busy/ready=%b%b end busy=%b want 11/0", bs, rs, be);
        end
    endtask

    task automatic test_bubbles();
        logic [31:0] res; logic ovf, bs, rs, be; int x, lag; bit to;
        logic [31:0] q[$];
        q = '{32'hFFFF, 32'h1, 32'h2};
        run_job(3, q, 2, 2, 0, res, ovf, x, lag, bs, rs, be, to);
        n_cmp++;
        if (to || res !== 32'h10002 || x != 3 || lag != 0) begin
            n_err++; $display("FAIL bubbles: result=%h xfers=%0d lag=%0d timeout=%0d want 10002/3/0", res, x, lag, to);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] res; logic ovf, bs, rs, be; int x, lag; bit to;
        logic [31:0] q[$];
        q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_job(2, q, 0, 1, 0, res, ovf, x, lag, bs, rs, be, to);
        n_cmp++;
        if (to || res !== 32'hFFFF_FFFE || ovf !== 1'b1) begin
            n_err++; $display("FAIL overflow_set: result=%h ovf=%b want FFFFFFFE/1", res, ovf);
        end
        n_cmp++;
        if (bus.overflow !== 1'b1 || bus.result !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL overflow_hold: ovf=%b result=%h want 1/FFFFFFFE", bus.overflow, bus.result);
        end
        q = '{32'd1};
        run_job(1, q, 0, 0, 0, res, ovf, x, lag, bs, rs, be, to);
        n_cmp++;
        if (to || res !== 32'd1 || ovf !== 1'b0) begin
            n_err++; $display("FAIL overflow_clear: result=%h ovf=%b want 1/0", res, ovf);
        end
    endtask

    task automatic test_zero_length();
        logic [31:0] res; logic ovf, bs, rs, be; int x, lag; bit to;
        logic [31:0] q[$];
        q = {};
        run_job(0, q, 0, 0, 0, res, ovf, x, lag, bs, rs, be, to);
        n_cmp++;
        if (to || lag != 0 || res !== 32'd0 || ovf !== 1'b0) begin
            n_err++; $display("FAIL zero_len_done: lag=%0d result=%h ovf=%b timeout=%0d want 0/0/0", lag, res, ovf, to);
        end
        n_cmp++;
        if (rs !== 1'b0 || bs !== 1'b1 || be !== 1'b0 || bus.ready !== 1'b0) begin
            n_err++; $display("FAIL zero_len_ready: ready=%b busy=%b end busy=%b want 0/1/0", rs, bs, be);
        end
    endtask

    task automatic test_start_busy();
        logic [31:0] res; logic ovf, bs, rs, be; int x, lag; bit to;
        logic [31:0] q[$];
        q = '{32'd7, 32'd8};
        run_job(2, q, 1, 1, 5, res, ovf, x, lag, bs, rs, be, to);
        n_cmp++;
        if (to || res !== 32'd15 || x != 2 || lag != 0) begin
            n_err++; $display("FAIL start_busy: result=%0d xfers=%0d lag=%0d timeout=%0d want 15/2/0", res, x, lag, to);
        end
    endtask

    // Runs chain with start in the first idle cycle after each done.
    task automatic test_back_to_back();
        logic [31:0] res; logic ovf, bs, rs, be; int x, lag; bit to;
        logic [31:0] q[$];
        logic [32:0] exp;
        logic [15:0] a, b;
        int len;
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(10, 1);
            q = {};
            for (int i = 0; i < len; i++) begin
                a = 16'($urandom); b = 16'($urandom);
                if (r % 2 == 0) q.push_back(32'($urandom_range(32'hFFFF_FFFF, 32'hC000_0000)));
                else            q.push_back({16'd0, a} * {16'd0, b});
            end
            exp = model_sum(q);
            run_job(len, q, 0, 2, 0, res, ovf, x, lag, bs, rs, be, to);
            n_cmp++;
            if (to || res !== exp[31:0] || ovf !== exp[32]) begin
                n_err++; $display("FAIL rand_sum[%0d]: result=%h ovf=%b want %h/%b", r, res, ovf, exp[31:0], exp[32]);
            end
            n_cmp++;
            if (x != len || lag != 0 || bs !== 1'b1 || rs !== 1'b1 || be !== 1'b0) begin
                n_err++; $display("FAIL rand_timing[%0d]: xfers=%0d lag=%0d busy/ready=%b%b end=%b want %0d/0/11/0",
                                  r, x, lag, bs, rs, be, len);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.length = '0;
        bus.valid = 1'b0;
        bus.product = '0;
        test_reset();
        test_basic();
        test_bubbles();
        test_overflow();
        test_zero_length();
        test_start_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
